// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    // Encoding driven on lanes that carry no valid instruction.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One queued instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Word-align a redirect target by clearing the byte offset bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_queue_unit_iqueue.sv
// W-write / W-read circular instruction queue with flush.
// Enqueue writes FETCH_WIDTH entries at the tail. Dequeue pops min(count, FETCH_WIDTH)
// entries from the head. Flush empties the queue and overrides both.
module fetch_iqueue
    import fetch_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned QUEUE_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                enq,
    input  logic                                deq,
    input  fetch_entry_t [FETCH_WIDTH-1:0]      wr_data,
    output fetch_entry_t [FETCH_WIDTH-1:0]      rd_data,
    output logic [$clog2(QUEUE_DEPTH):0]        count
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t   mem [QUEUE_DEPTH];
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  enq_n;
    logic [CW-1:0]  deq_n;

    // Number of entries pushed and popped this cycle.
    always_comb begin
        enq_n = '0;
        deq_n = '0;
        if (enq) begin
            enq_n = CW'(FETCH_WIDTH);
        end
        if (deq) begin
            deq_n = (count_q < CW'(FETCH_WIDTH)) ? count_q : CW'(FETCH_WIDTH);
        end
    end

    // Head/tail/count bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + deq_n[PW-1:0];
            if (enq) begin
                tail_q <= tail_q + PW'(FETCH_WIDTH);
            end
            count_q <= count_q + enq_n - deq_n;
        end
    end

    // Entry storage; written only when a whole group is accepted.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
                mem[tail_q + PW'(k)] <= wr_data[k];
            end
        end
    end

    // Present the oldest FETCH_WIDTH entries, lane 0 at the head.
    always_comb begin
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            rd_data[i] = mem[head_q + PW'(i)];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// N-wide instruction fetch front end: reads FETCH_WIDTH consecutive ROM words per cycle
// into a circular queue and presents up to FETCH_WIDTH entries to decode.
// The ROM image is supplied through ROM_INIT (word i at bits [i*XLEN +: XLEN]).
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned              FETCH_WIDTH = 2,
    parameter int unsigned              QUEUE_DEPTH = 8,
    parameter int unsigned              IMEM_WORDS  = 256,
    parameter logic [XLEN-1:0]          RESET_PC    = '0,
    parameter logic [XLEN*IMEM_WORDS-1:0] ROM_INIT  = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            redirect_valid,
    input  logic [XLEN-1:0]                 redirect_pc,
    input  logic                            dec_ready,
    output logic [FETCH_WIDTH-1:0]          out_valid,
    output logic [FETCH_WIDTH*XLEN-1:0]     out_instr,
    output logic [FETCH_WIDTH*XLEN-1:0]     out_pc,
    output logic [$clog2(QUEUE_DEPTH):0]    queue_count
);

    localparam int unsigned IW = $clog2(IMEM_WORDS);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned BW = $clog2(XLEN * IMEM_WORDS);

    logic [XLEN-1:0]                 pc_q;
    fetch_entry_t [FETCH_WIDTH-1:0]  wr_data;
    fetch_entry_t [FETCH_WIDTH-1:0]  rd_data;
    logic [CW-1:0]                   count;
    logic                            has_space;
    logic                            fetch_en;
    logic                            pop;

    // Space is judged on the registered count; same-cycle pops are not credited.
    assign has_space = (CW'(QUEUE_DEPTH) - count) >= CW'(FETCH_WIDTH);
    assign fetch_en  = !redirect_valid && has_space;
    assign pop       = dec_ready && !redirect_valid;

    // Build the fetch group from consecutive ROM words, wrapping the word index.
    always_comb begin
        logic [IW-1:0] idx;
        logic [BW-1:0] bit_pos;
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            idx              = pc_q[IW+1:2] + IW'(k);
            bit_pos          = BW'(idx) * BW'(XLEN);
            wr_data[k].instr = ROM_INIT[bit_pos +: XLEN];
            wr_data[k].pc    = pc_q + XLEN'(4 * k);
        end
    end

    // Fetch PC: redirect wins, otherwise advance only when a group is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= align_pc(redirect_pc);
        end else if (fetch_en) begin
            pc_q <= pc_q + XLEN'(4 * FETCH_WIDTH);
        end
    end

    fetch_iqueue #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_iqueue (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect_valid),
        .enq     (fetch_en),
        .deq     (pop),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .count   (count)
    );

    // Decode-facing lanes; empty lanes carry a NOP and PC 0.
    always_comb begin
        out_valid = '0;
        out_instr = '0;
        out_pc    = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            if (count > CW'(i)) begin
                out_valid[i]              = 1'b1;
                out_instr[i*XLEN +: XLEN] = rd_data[i].instr;
                out_pc[i*XLEN +: XLEN]    = rd_data[i].pc;
            end else begin
                out_instr[i*XLEN +: XLEN] = NOP_INSTR;
            end
        end
    end

    assign queue_count = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: scoreboard of expected (instr, pc) in program order,
// popped as decode consumes valid lanes.
module tb_fetch_queue_unit;
    import fetch_pkg::*;

    localparam int W     = 2;
    localparam int D     = 8;
    localparam int WORDS = 256;

    function automatic logic [32*WORDS-1:0] ramp_image();
        logic [32*WORDS-1:0] r;
        r = '0;
        for (int i = 0; i < WORDS; i++) begin
            r[i*32 +: 32] = 32'(i);
        end
        return r;
    endfunction

    localparam logic [32*WORDS-1:0] ROM_IMG = ramp_image();

    logic            clk = 1'b0;
    logic            reset;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            dec_ready;
    logic [W-1:0]    out_valid;
    logic [W*32-1:0] out_instr;
    logic [W*32-1:0] out_pc;
    logic [3:0]      queue_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;
    exp_t sb[$];

    fetch_queue_unit #(
        .FETCH_WIDTH (W),
        .QUEUE_DEPTH (D),
        .IMEM_WORDS  (WORDS),
        .RESET_PC    (32'h0),
        .ROM_INIT    (ROM_IMG)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .queue_count    (queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected program-order stream: ROM[i] = i, index wraps at WORDS.
    task automatic push_range(input logic [31:0] start_pc, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.pc    = start_pc + 32'(4 * k);
            e.instr = (e.pc >> 2) & 32'(WORDS - 1);
            sb.push_back(e);
        end
    endtask

    // Compare every valid lane (which decode consumes at the next edge) against the scoreboard.
    task automatic drain_check(input string tag);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            if (out_valid[i]) begin
                chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({tag, "_instr"}, 64'(out_instr[i*32 +: 32]), 64'(e.instr));
                    chk({tag, "_pc"}, 64'(out_pc[i*32 +: 32]), 64'(e.pc));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt[6];
        exp_cnt = '{2, 4, 6, 8, 8, 8};

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        #2;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_count", 64'(queue_count), 64'(0));
        chk("rst_instr", 64'(out_instr), {NOP_INSTR, NOP_INSTR});
        chk("rst_pc", 64'(out_pc), 64'(0));
        tick();
        tick();
        reset     = 1'b0;
        dec_ready = 1'b1;

        // Steady streaming with decode always ready.
        push_range(32'h0, 16);
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("stream_count", 64'(queue_count), 64'(2));
            drain_check("stream");
        end
        chk("stream_sb_empty", 64'(sb.size()), 64'(0));

        // Backpressure: queue fills to depth and fetch stalls.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        tick();
        redirect_valid = 1'b0;
        chk("bp_flush_count", 64'(queue_count), 64'(0));
        chk("bp_flush_valid", 64'(out_valid), 64'(0));
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("bp_count", 64'(queue_count), 64'(exp_cnt[j]));
        end
        sb.delete();
        push_range(32'h0, 12);
        dec_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            drain_check("bp_drain");
            tick();
        end

        // Mid-stream redirect to an unaligned target.
        sb.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        tick();
        redirect_valid = 1'b0;
        chk("redir_count", 64'(queue_count), 64'(0));
        chk("redir_valid", 64'(out_valid), 64'(0));
        chk("redir_instr", 64'(out_instr), {NOP_INSTR, NOP_INSTR});
        push_range(32'h40, 8);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("redir_stream_count", 64'(queue_count), 64'(2));
            drain_check("redir");
        end

        // Redirect with a full queue and decode ready: flush wins over the pop.
        dec_ready = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        chk("full_count", 64'(queue_count), 64'(8));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        dec_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("full_redir_count", 64'(queue_count), 64'(0));
        chk("full_redir_valid", 64'(out_valid), 64'(0));
        sb.delete();
        push_range(32'h100, 4);
        tick();
        chk("full_redir_refill", 64'(queue_count), 64'(2));
        drain_check("full_redir");
        tick();
        drain_check("full_redir2");

        // ROM index wrap at the end of the image.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FC;
        tick();
        redirect_valid = 1'b0;
        sb.delete();
        push_range(32'h3FC, 6);
        for (int j = 0; j < 3; j++) begin
            tick();
            drain_check("wrap");
        end

        // Asynchronous reset between edges with a partly full queue.
        dec_ready = 1'b0;
        tick();
        tick();
        chk("pre_reset_count", 64'(queue_count), 64'(6));
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_count", 64'(queue_count), 64'(0));
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_instr", 64'(out_instr), {NOP_INSTR, NOP_INSTR});
        chk("async_rst_pc", 64'(out_pc), 64'(0));
        #2;
        reset     = 1'b0;
        dec_ready = 1'b1;
        sb.delete();
        push_range(32'h0, 8);
        for (int j = 0; j < 4; j++) begin
            tick();
            drain_check("restart");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
